// File: rtl/latch_input_conditioner.sv
// ----------------------------------------------------------------------------
// latch_input_conditioner
//
// Front end for the board's D-latch. It takes a raw push-button and a raw
// slide switch and produces clean, clock-synchronous signals:
//   E_LEVEL   - debounced button level, drives the latch E input
//   E_PULSE   - one-cycle strobe on every accepted press
//   D_OUT     - synchronised (not debounced) switch, drives the latch D input
//   PRESS_CNT - 8-bit wrapping count of accepted presses, for the display
//
// Both raw inputs pass through a 2-flop synchroniser. The synchronised
// button is qualified by a four-state counter FSM. A level is accepted only
// after it has been seen for STABLE_CYCLES consecutive clocks. Any opposite
// sample during qualification restarts the count from scratch.
//
// Build option:
//   BTN_ACTIVE_LOW_EN - when defined, BTN_IN is inverted ahead of the
//                       synchroniser so that pull-up buttons reading 0 when
//                       pressed are handled. The synchroniser still resets to
//                       0, which then means "not pressed". SW_IN is never
//                       inverted.
// ----------------------------------------------------------------------------
module latch_input_conditioner #(
    parameter int STABLE_CYCLES = 1000000,  // clocks a level must hold, 1..2^CNT_W-1
    parameter int CNT_W         = 20        // debounce counter width
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_IN,
    input  logic       SW_IN,
    output logic       D_OUT,
    output logic       E_LEVEL,
    output logic       E_PULSE,
    output logic [7:0] PRESS_CNT
);

    // Terminal count of the qualification counter. The transition fires on
    // the edge where the counter already holds STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Synchroniser channel assignment
    localparam int CH_BTN = 0;
    localparam int CH_SW  = 1;
    localparam int N_CH   = 2;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input polarity
    // ------------------------------------------------------------------
    logic btn_raw;

`ifdef BTN_ACTIVE_LOW_EN
    assign btn_raw = ~BTN_IN;
`else
    assign btn_raw = BTN_IN;
`endif

    logic [N_CH-1:0] raw_vec;
    logic [N_CH-1:0] sync_vec;

    assign raw_vec[CH_BTN] = btn_raw;
    assign raw_vec[CH_SW]  = SW_IN;

    // ------------------------------------------------------------------
    // Two-flop synchronisers, one per raw input
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;

            // Resolve metastability on the asynchronous input; reset to 0 ("inactive")
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw_vec[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            assign sync_vec[gi] = sync2_reg;
        end
    endgenerate

    logic btn_s;
    logic sw_s;

    assign btn_s = sync_vec[CH_BTN];
    assign sw_s  = sync_vec[CH_SW];

    // ------------------------------------------------------------------
    // Data path: one output register after the synchroniser (3 edges total)
    // ------------------------------------------------------------------
    logic d_out_reg;

    // Register the synchronised switch so D_OUT is glitch-free and fully registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            d_out_reg <= 1'b0;
        end else begin
            d_out_reg <= sw_s;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM with registered outputs
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             e_level_reg;
    logic             e_pulse_reg;
    logic [7:0]       press_cnt_reg;

    // Qualify button levels; the strobe and press count update on acceptance only
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_RELEASED;
            cnt_reg       <= '0;
            e_level_reg   <= 1'b0;
            e_pulse_reg   <= 1'b0;
            press_cnt_reg <= 8'd0;
        end else begin
            // Strobe is high only on the cycle a press is accepted
            e_pulse_reg <= 1'b0;

            case (state_reg)
                ST_RELEASED: begin
                    if (btn_s) begin
                        state_reg <= ST_PRESS_WAIT;
                        cnt_reg   <= '0;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!btn_s) begin
                        // Short glitch: drop back without touching outputs
                        state_reg <= ST_RELEASED;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg     <= ST_PRESSED;
                        e_level_reg   <= 1'b1;
                        e_pulse_reg   <= 1'b1;
                        press_cnt_reg <= press_cnt_reg + 8'd1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                ST_PRESSED: begin
                    if (!btn_s) begin
                        state_reg <= ST_RELEASE_WAIT;
                        cnt_reg   <= '0;
                    end
                end

                ST_RELEASE_WAIT: begin
                    if (btn_s) begin
                        // Release bounce: still pressed, and not a new press
                        state_reg <= ST_PRESSED;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= ST_RELEASED;
                        e_level_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_reg   <= ST_RELEASED;
                    cnt_reg     <= '0;
                    e_level_reg <= 1'b0;
                end
            endcase
        end
    end

    assign D_OUT     = d_out_reg;
    assign E_LEVEL   = e_level_reg;
    assign E_PULSE   = e_pulse_reg;
    assign PRESS_CNT = press_cnt_reg;

endmodule

// File: tb/tb_latch_input_conditioner.sv
// ----------------------------------------------------------------------------
// Testbench for latch_input_conditioner (STABLE_CYCLES=4, CNT_W=3).
// The stimulus steps push timed expectations into a scoreboard queue. Each
// clock tick pops the entries that are due and compares the DUT outputs with
// immediate assertions.
// ----------------------------------------------------------------------------
module tb_latch_input_conditioner;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_IN = 1'b0;
    logic       SW_IN = 1'b0;
    logic       D_OUT;
    logic       E_LEVEL;
    logic       E_PULSE;
    logic [7:0] PRESS_CNT;

    latch_input_conditioner #(
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_IN   (BTN_IN),
        .SW_IN    (SW_IN),
        .D_OUT    (D_OUT),
        .E_LEVEL  (E_LEVEL),
        .E_PULSE  (E_PULSE),
        .PRESS_CNT(PRESS_CNT)
    );

    always #5 CLK = ~CLK;

    // Field-select mask bits
    localparam logic [3:0] M_D   = 4'b0001;
    localparam logic [3:0] M_EL  = 4'b0010;
    localparam logic [3:0] M_EP  = 4'b0100;
    localparam logic [3:0] M_PC  = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    typedef struct {
        int         due;
        string      tag;
        logic [3:0] mask;
        logic       d;
        logic       el;
        logic       ep;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Queue an expectation dly edges from now
    task automatic expect_at(input int dly, input string tag, input logic [3:0] mask,
                             input logic d, input logic el, input logic ep,
                             input logic [7:0] pc);
        exp_t e;
        e.due  = cyc + dly;
        e.tag  = tag;
        e.mask = mask;
        e.d    = d;
        e.el   = el;
        e.ep   = ep;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    // Queue the same expectation for every edge in [from, to]
    task automatic expect_span(input int from, input int to, input string tag,
                               input logic [3:0] mask, input logic d, input logic el,
                               input logic ep, input logic [7:0] pc);
        for (int k = from; k <= to; k++) begin
            expect_at(k, tag, mask, d, el, ep, pc);
        end
    endtask

    task automatic check_field(input string tag, input string fld,
                               input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s cyc=%0d observed=%0h expected=%0h", tag, fld, cyc, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, retire due entries
    task automatic tick();
        int i;
        @(posedge CLK);
        cyc++;
        #1;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].due == cyc) begin
                $display("cyc=%0d %s d=%b el=%b ep=%b pc=%0d", cyc, exp_q[i].tag,
                         D_OUT, E_LEVEL, E_PULSE, PRESS_CNT);
                if (exp_q[i].mask[0]) check_field(exp_q[i].tag, "D_OUT", {7'd0, D_OUT}, {7'd0, exp_q[i].d});
                if (exp_q[i].mask[1]) check_field(exp_q[i].tag, "E_LEVEL", {7'd0, E_LEVEL}, {7'd0, exp_q[i].el});
                if (exp_q[i].mask[2]) check_field(exp_q[i].tag, "E_PULSE", {7'd0, E_PULSE}, {7'd0, exp_q[i].ep});
                if (exp_q[i].mask[3]) check_field(exp_q[i].tag, "PRESS_CNT", PRESS_CNT, exp_q[i].pc);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        int bounce_p[8];
        int rel_p[4];
        int guard;
        bounce_p = '{1, 1, 1, 0, 1, 1, 0, 1};
        rel_p    = '{0, 0, 1, 0};

        // Reset held 3 cycles with both inputs high: everything stays 0
        RST = 1'b1; BTN_IN = 1'b1; SW_IN = 1'b1;
        expect_span(1, 3, "reset", M_ALL, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) tick();

        RST = 1'b0; BTN_IN = 1'b0; SW_IN = 1'b0;
        expect_span(1, 8, "idle", M_ALL, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (8) tick();

        // Clean press held 20 cycles, with a switch toggle running alongside
        BTN_IN = 1'b1;
        expect_span(1, 6, "press_pre", M_EL | M_EP, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_at(7, "press_edge", M_EL | M_EP | M_PC, 1'b0, 1'b1, 1'b1, 8'd1);
        expect_span(8, 20, "press_hold", M_EL | M_EP | M_PC, 1'b0, 1'b1, 1'b0, 8'd1);
        expect_span(1, 4, "sw_lo", M_D, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_span(5, 9, "sw_hi", M_D, 1'b1, 1'b0, 1'b0, 8'd0);
        expect_span(10, 20, "sw_lo2", M_D, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 20; k++) begin
            if (k == 2) SW_IN = 1'b1;
            if (k == 7) SW_IN = 1'b0;
            tick();
        end

        // Clean release
        BTN_IN = 1'b0;
        expect_span(1, 6, "rel_pre", M_EL | M_EP, 1'b0, 1'b1, 1'b0, 8'd0);
        expect_span(7, 20, "rel_done", M_EL | M_EP | M_PC, 1'b0, 1'b0, 1'b0, 8'd1);
        repeat (20) tick();

        // Bouncy press: one pulse, 7 edges after the last 0->1
        expect_span(1, 13, "bounce_pre", M_EL | M_EP, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_at(14, "bounce_edge", M_EL | M_EP | M_PC, 1'b0, 1'b1, 1'b1, 8'd2);
        expect_span(15, 24, "bounce_hold", M_EL | M_EP | M_PC, 1'b0, 1'b1, 1'b0, 8'd2);
        for (int k = 0; k < 8; k++) begin
            BTN_IN = bounce_p[k][0];
            tick();
        end
        BTN_IN = 1'b1;
        repeat (16) tick();

        // Bouncy release: level falls 7 edges after the last 1->0
        expect_span(1, 9, "rbounce_pre", M_EL | M_EP, 1'b0, 1'b1, 1'b0, 8'd0);
        expect_span(10, 16, "rbounce_done", M_EL | M_EP | M_PC, 1'b0, 1'b0, 1'b0, 8'd2);
        for (int k = 0; k < 4; k++) begin
            BTN_IN = rel_p[k][0];
            tick();
        end
        BTN_IN = 1'b0;
        repeat (12) tick();

        // Press counter wrap: 256 clean press/release pairs from reset
        RST = 1'b1;
        expect_at(1, "wrap_rst", M_ALL, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        RST = 1'b0;
        for (int p = 1; p <= 256; p++) begin
            BTN_IN = 1'b1;
            expect_at(7, $sformatf("wrap_press%0d", p), M_EP | M_PC, 1'b0, 1'b0, 1'b1, 8'(p));
            repeat (8) tick();
            BTN_IN = 1'b0;
            expect_at(7, $sformatf("wrap_rel%0d", p), M_EL, 1'b0, 1'b0, 1'b0, 8'd0);
            repeat (8) tick();
        end

        // Reset pulse during PRESS_WAIT with the button still held
        BTN_IN = 1'b1;
        expect_span(1, 4, "midq_pre", M_EL | M_EP, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_at(5, "midq_rst", M_ALL, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_span(6, 11, "midq_requal", M_EL | M_EP, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_at(12, "midq_edge", M_EL | M_EP | M_PC, 1'b0, 1'b1, 1'b1, 8'd1);
        expect_span(13, 15, "midq_hold", M_EL | M_EP | M_PC, 1'b0, 1'b1, 1'b0, 8'd1);
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (10) tick();

        // Drain any remaining expectations within a bounded window
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed=%0d pending expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_input_conditioner.md
Name: latch_input_conditioner

Overview:
- Upstream stage for the team's D-latch: turns a raw push-button and a raw slide switch into clean, clock-synchronous enable and data signals.
- Synchronises both inputs and debounces the button with a counter-based FSM.
- Outputs:
  - a debounced enable level (E_LEVEL), which drives the latch's E input;
  - a one-cycle press strobe (E_PULSE);
  - a synchronised data bit (D_OUT), which drives the latch's D input;
  - a press counter for the board display.

Parameters:
- STABLE_CYCLES, 1000000, consecutive clocks the synchronised button must hold a level to be accepted (10 ms at 100 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 20, width of the debounce counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- BTN_IN  input  1  raw asynchronous push-button (enable source).
- SW_IN  input  1  raw asynchronous slide switch (data source).
- D_OUT  output  1  synchronised SW_IN; drives latch D.
- E_LEVEL  output  1  debounced button level; drives latch E.
- E_PULSE  output  1  single-cycle strobe on each accepted press.
- PRESS_CNT  output  8  count of accepted presses, wrapping.

Behaviour:
- Clocking and reset: one clock CLK. RST is synchronous and active-high.
- RST=1 at an edge sets:
  - both 2-FF synchronisers to 0;
  - FSM to RELEASED, counter to 0;
  - D_OUT=0, E_LEVEL=0, E_PULSE=0, PRESS_CNT=0.
- RST has priority over every other event.
- Synchronisation: BTN_IN and SW_IN each pass through two flops (sync1 -> sync2). btn_s and sw_s are the sync2 outputs.
- D_OUT is a register loaded from sw_s, so an SW_IN change appears on D_OUT after 3 edges. D_OUT is not debounced.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: btn_s=1 -> PRESS_WAIT, cnt<=0. Otherwise hold.
  - PRESS_WAIT: btn_s=0 -> RELEASED (glitch rejected, no output change). Else if cnt==STABLE_CYCLES-1 -> PRESSED, E_LEVEL<=1, E_PULSE<=1, PRESS_CNT<=PRESS_CNT+1. Else cnt<=cnt+1.
  - PRESSED: btn_s=0 -> RELEASE_WAIT, cnt<=0. Otherwise hold.
  - RELEASE_WAIT: btn_s=1 -> PRESSED (release bounce rejected, E_LEVEL stays 1, no new pulse). Else if cnt==STABLE_CYCLES-1 -> RELEASED, E_LEVEL<=0. Else cnt<=cnt+1.
- E_PULSE is a register that defaults to 0 every cycle. It is high for exactly one cycle, coincident with E_LEVEL's first high cycle.
- Latency: the first edge sampling BTN_IN=1 is edge 1. For a clean press, E_LEVEL and E_PULSE go high after edge 3+STABLE_CYCLES. Release behaves the same way for E_LEVEL falling; no pulse on release.
- Any opposite level on btn_s during a WAIT state restarts qualification from scratch, with no partial credit.
- PRESS_CNT is 8-bit modulo: 255 + 1 -> 0, and no flag is raised.
- Reset mid-operation: state is lost. If the button is still held after RST falls, the press is re-qualified in full and produces a new pulse and a count of 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro BTN_ACTIVE_LOW_EN.
- Defined: BTN_IN is inverted before sync1, for pull-up buttons that read 0 when pressed. Reset still loads the synchronisers with 0, meaning "not pressed".
- Undefined: BTN_IN is active-high, 1 meaning pressed.
- SW_IN polarity is never affected.

Test Plan:
All scenarios use STABLE_CYCLES=4, CNT_W=3.
- Reset: RST=1 for 3 cycles with BTN_IN=1, SW_IN=1 -> D_OUT=0, E_LEVEL=0, E_PULSE=0, PRESS_CNT=0 throughout reset.
- Clean press: BTN_IN 0->1, held 20 cycles -> E_PULSE=1 for exactly one cycle after edge 7, E_LEVEL=1 from edge 7, PRESS_CNT=1.
  - Then BTN_IN=0, held 20 cycles -> E_LEVEL=0 after edge 7 of the release, no pulse.
- Bounce: BTN_IN pattern 1,1,1,0,1,1,0,1 followed by steady 1 -> exactly one E_PULSE, 7 edges after the final 0->1 transition; PRESS_CNT=1.
  - Release bounce 0,0,1,0 followed by steady 0 -> E_LEVEL stays 1 until 7 edges after the final 1->0 transition.
- Data path: SW_IN toggles 0->1->0 with 5-cycle spacing -> D_OUT mirrors each transition 3 edges later, independent of the FSM state.
- Wrap: 256 clean press/release pairs -> PRESS_CNT reads 255 after the 255th press and 0 after the 256th.
- Reset mid-qualification: RST pulsed for 1 cycle while in PRESS_WAIT with BTN_IN held 1 -> no pulse around reset.
  - E_PULSE then fires 7 edges after RST deasserts.
  - PRESS_CNT=1.
